// File: rtl/cic_interp_sequencer.sv
// Sequencer between the TX sample FIFO and the interpolating CIC: paces the CIC
// with a divided clock enable and answers its sample requests from the FIFO.
module cic_interp_sequencer #(
  parameter int IBITS       = 20,
  parameter int CW          = 12,
  parameter int PRIME_DEPTH = 64,
  parameter int FLUSH_REQS  = 8,
  parameter int DIVW        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [DIVW-1:0]  rate_div,
  input  logic             clear_status,
  input  logic             fifo_empty,
  input  logic [CW-1:0]    fifo_count,
  input  logic [IBITS-1:0] fifo_i,
  input  logic [IBITS-1:0] fifo_q,
  output logic             fifo_rd,
  output logic             cic_ce,
  input  logic             cic_req,
  output logic [IBITS-1:0] x_real,
  output logic [IBITS-1:0] x_imag,
  output logic             active,
  output logic             underflow,
  output logic [15:0]      underflow_count
);

  localparam int FW = $clog2(FLUSH_REQS + 1);
  localparam logic [CW-1:0] PRIME_LVL  = CW'(PRIME_DEPTH);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_REQS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_FLUSH} state_t;

  state_t           state_q, state_d;
  logic [DIVW-1:0]  div_cnt_q;
  logic [DIVW-1:0]  div_eff;
  logic             div_wrap;
  logic [FW-1:0]    flush_cnt_q;
  logic             flush_done;
  logic             stuff;
  logic             cic_ce_q;
  logic             active_q;
  logic             underflow_q;
  logic [15:0]      underflow_count_q;
  logic [IBITS-1:0] x_real_q, x_imag_q;

  // A rate of 0 behaves like 1 so the strobe never stalls.
  assign div_eff    = (rate_div == '0) ? DIVW'(1) : rate_div;
  assign div_wrap   = (div_cnt_q >= div_eff - DIVW'(1));
  assign flush_done = (flush_cnt_q == FLUSH_LAST);
  assign stuff      = (state_q == S_RUN) && cic_req && fifo_empty;

  // Gated by reset so a request on the resetting edge never pops the FIFO.
  assign fifo_rd = (state_q == S_RUN) && cic_req && !fifo_empty && !reset;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (run) state_d = S_PRIME;
      S_PRIME: begin
        if (!run) state_d = S_FLUSH;
        else if (fifo_count >= PRIME_LVL) state_d = S_RUN;
      end
      S_RUN:   if (!run) state_d = S_FLUSH;
      S_FLUSH: if (cic_req && flush_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= S_IDLE;
      div_cnt_q         <= '0;
      flush_cnt_q       <= '0;
      cic_ce_q          <= 1'b0;
      active_q          <= 1'b0;
      underflow_q       <= 1'b0;
      underflow_count_q <= '0;
      x_real_q          <= '0;
      x_imag_q          <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= (state_d != S_IDLE);

      if (state_q != S_IDLE && state_d != S_IDLE) begin
        if (div_wrap) begin
          div_cnt_q <= '0;
          cic_ce_q  <= 1'b1;
        end else begin
          div_cnt_q <= div_cnt_q + DIVW'(1);
          cic_ce_q  <= 1'b0;
        end
      end else begin
        div_cnt_q <= '0;
        cic_ce_q  <= 1'b0;
      end

      // Held sample only moves on a request; anything but a real pop loads zero.
      if (cic_req) begin
        if (state_q == S_RUN && !fifo_empty) begin
          x_real_q <= fifo_i;
          x_imag_q <= fifo_q;
        end else begin
          x_real_q <= '0;
          x_imag_q <= '0;
        end
      end

      if (state_q == S_FLUSH) begin
        if (cic_req) flush_cnt_q <= flush_done ? '0 : flush_cnt_q + FW'(1);
      end else begin
        flush_cnt_q <= '0;
      end

      if (clear_status) begin
        underflow_q       <= 1'b0;
        underflow_count_q <= '0;
      end else if (stuff) begin
        underflow_q <= 1'b1;
        if (underflow_count_q != 16'hFFFF) underflow_count_q <= underflow_count_q + 16'd1;
      end
    end
  end

  assign cic_ce          = cic_ce_q;
  assign active          = active_q;
  assign underflow       = underflow_q;
  assign underflow_count = underflow_count_q;
  assign x_real          = x_real_q;
  assign x_imag          = x_imag_q;

endmodule

// File: tb/tb_cic_interp_sequencer.sv
// Randomized bench for cic_interp_sequencer: a queue-backed FIFO feeds the DUT and a
// behavioural model predicts every output cycle by cycle.
module tb_cic_interp_sequencer;

  localparam int IBITS = 20;
  localparam int CW    = 12;
  localparam int DIVW  = 16;
  localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2, M_FLUSH = 3;

  logic             clock = 1'b0;
  logic             reset, run, clear_status, fifo_empty, cic_req;
  logic [DIVW-1:0]  rate_div;
  logic [CW-1:0]    fifo_count;
  logic [IBITS-1:0] fifo_i, fifo_q;
  logic             fifo_rd, cic_ce, active, underflow;
  logic [IBITS-1:0] x_real, x_imag;
  logic [15:0]      underflow_count;

  cic_interp_sequencer #(.IBITS(IBITS), .CW(CW), .PRIME_DEPTH(64), .FLUSH_REQS(8), .DIVW(DIVW)) dut (
    .clock(clock), .reset(reset), .run(run), .rate_div(rate_div), .clear_status(clear_status),
    .fifo_empty(fifo_empty), .fifo_count(fifo_count), .fifo_i(fifo_i), .fifo_q(fifo_q),
    .fifo_rd(fifo_rd), .cic_ce(cic_ce), .cic_req(cic_req), .x_real(x_real), .x_imag(x_imag),
    .active(active), .underflow(underflow), .underflow_count(underflow_count)
  );

  always #5 clock = ~clock;

  logic [39:0] fq[$];
  int n_tests = 0;
  int n_fail  = 0;

  int          m_mode = M_IDLE;
  int          m_ph = 0, m_flush = 0, m_cnt = 0;
  bit          m_ce = 0, m_uf = 0;
  logic [19:0] m_xr = '0, m_xi = '0;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_count = (fq.size() > 4095) ? 12'hFFF : 12'(fq.size());
    if (fq.size() != 0) begin
      fifo_i = fq[0][39:20];
      fifo_q = fq[0][19:0];
    end else begin
      fifo_i = 20'hDEAD5;
      fifo_q = 20'hBEEF3;
    end
  endtask

  task automatic push_n(input int n);
    logic [39:0] w;
    for (int k = 0; k < n; k++) begin
      w[39:20] = 20'($urandom());
      w[19:0]  = 20'($urandom());
      fq.push_back(w);
    end
  endtask

  // Reference behaviour for one rising edge, from the inputs presented in that cycle.
  task automatic model_edge(input bit have, input logic [39:0] head, input int cnt_in);
    int nxt, eff;
    if (reset) begin
      m_mode = M_IDLE; m_ph = 0; m_flush = 0; m_ce = 0; m_uf = 0; m_cnt = 0;
      m_xr = '0; m_xi = '0;
      return;
    end
    nxt = m_mode;
    eff = (rate_div == 0) ? 1 : int'(rate_div);
    if (cic_req) begin
      if (m_mode == M_RUN && have) begin
        m_xr = head[39:20]; m_xi = head[19:0];
      end else begin
        m_xr = '0; m_xi = '0;
      end
      if (m_mode == M_RUN && !have) begin
        m_uf = 1;
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end
      if (m_mode == M_FLUSH) m_flush++;
    end
    if (clear_status) begin
      m_uf = 0; m_cnt = 0;
    end
    case (m_mode)
      M_IDLE:  if (run) nxt = M_PRIME;
      M_PRIME: if (!run) nxt = M_FLUSH; else if (cnt_in >= 64) nxt = M_RUN;
      M_RUN:   if (!run) nxt = M_FLUSH;
      default: if (m_flush == 8) nxt = M_IDLE;
    endcase
    if (m_mode != M_FLUSH || nxt == M_IDLE) m_flush = 0;
    // Strobe every eff cycles of activity, counted from entry into PRIME.
    if (m_mode != M_IDLE && nxt != M_IDLE) begin
      if (m_ph + 1 >= eff) begin m_ce = 1; m_ph = 0; end
      else begin m_ce = 0; m_ph++; end
    end else begin
      m_ce = 0; m_ph = 0;
    end
    m_mode = nxt;
  endtask

  task automatic tick(input bit quiet);
    bit exp_rd, rd_seen, have;
    logic [39:0] head;
    int cnt_in;
    drive_fifo();
    @(negedge clock);
    have   = (fq.size() != 0);
    head   = have ? fq[0] : 40'h0;
    cnt_in = fq.size();
    exp_rd = !reset && (m_mode == M_RUN) && cic_req && have;
    chk("fifo_rd", 40'(fifo_rd), 40'(exp_rd));
    rd_seen = fifo_rd;
    @(posedge clock);
    model_edge(have, head, cnt_in);
    if (rd_seen && fq.size() != 0) void'(fq.pop_front());
    #1;
    chk("cic_ce", 40'(cic_ce), 40'(m_ce));
    chk("x_real", 40'(x_real), 40'(m_xr));
    chk("x_imag", 40'(x_imag), 40'(m_xi));
    chk("active", 40'(active), 40'(m_mode != M_IDLE));
    chk("uflow", 40'(underflow), 40'(m_uf));
    chk("uf_cnt", 40'(underflow_count), 40'(m_cnt));
    if (cic_req && !quiet)
      $display("[TB] req t=%0t mode=%0d rd=%0b x=%05h/%05h uf=%0d", $time, m_mode, rd_seen, x_real, x_imag, underflow_count);
  endtask

  task automatic rand_cycles(input int n, input int req_pct);
    for (int k = 0; k < n; k++) begin
      cic_req      = ($urandom_range(0, 99) < req_pct);
      clear_status = ($urandom_range(0, 59) == 0);
      tick(1'b0);
    end
    cic_req = 0; clear_status = 0;
  endtask

  initial begin
    reset = 1; run = 0; clear_status = 0; cic_req = 0; rate_div = 16'd4;
    drive_fifo();
    tick(1'b0); tick(1'b0);
    chk("rst_cnt", 40'(underflow_count), 40'h0);
    reset = 0;

    // PRIME boundary: fill crosses 64 while priming, requests answered with zero.
    push_n(60);
    run = 1;
    for (int k = 0; k < 10; k++) begin
      push_n(1);
      cic_req = k[0];
      tick(1'b0);
    end
    push_n(30);
    rand_cycles(60, 50);
    rate_div = 16'd1;
    rand_cycles(30, 50);
    rate_div = 16'd3;
    rand_cycles(40, 50);
    rate_div = 16'd0;
    rand_cycles(150, 60);

    // Drained: five stuffed requests, then clear coincident with a sixth.
    clear_status = 1; tick(1'b0); clear_status = 0;
    fq.delete();
    for (int k = 0; k < 5; k++) begin cic_req = 1; tick(1'b0); end
    chk("uf5_cnt", 40'(underflow_count), 40'd5);
    chk("uf5_flag", 40'(underflow), 40'd1);
    clear_status = 1; tick(1'b0); clear_status = 0; cic_req = 0;
    chk("clr_cnt", 40'(underflow_count), 40'd0);

    // Stop with run re-raised mid-flush, then full stop to IDLE.
    push_n(20);
    rate_div = 16'd2;
    run = 0;
    for (int k = 0; k < 30; k++) begin
      if (k == 6) run = 1;
      if (k == 6) push_n(80);
      cic_req = ($urandom_range(0, 1) == 1);
      tick(1'b0);
    end
    rand_cycles(60, 40);
    run = 0;
    for (int k = 0; k < 12; k++) begin cic_req = 1; tick(1'b0); end
    cic_req = 0;
    tick(1'b0);
    chk("idle_act", 40'(active), 40'd0);

    // Reset while a request is pending in RUN with data available.
    run = 1; push_n(70);
    rand_cycles(20, 50);
    cic_req = 1; reset = 1; tick(1'b0);
    reset = 0; cic_req = 0;
    chk("rst_x", 40'(x_real), 40'h0);

    // Saturation: long underflow stream at full rate.
    fq.delete(); push_n(64);
    run = 1; rate_div = 16'd1;
    cic_req = 1;
    for (int k = 0; k < 65650; k++) tick(1'b1);
    chk("uf_sat", 40'(underflow_count), 40'hFFFF);
    cic_req = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cic_interp_sequencer.md
Name: cic_interp_sequencer

Overview:
- Sequences the TX interpolating CIC.
- Generates its sample-enable strobe from a programmable divider and answers its input requests by popping I/Q pairs from the upstream show-ahead TX FIFO.
- Primes the FIFO before start, zero-stuffs and counts underflows, and flushes zeros into the filter on stop so the integrators settle to zero.
- Sits between the TX sample FIFO and the CIC interpolator.

Parameters:
- IBITS, 20, I/Q sample width (matches CIC input width).
- CW, 12, FIFO fill-count width.
- PRIME_DEPTH, 64, FIFO count required before leaving PRIME.
- FLUSH_REQS, 8, number of zero samples fed to the CIC on stop (≥ CIC STAGES+1).
- DIVW, 16, divider width.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; high requests transmit, low requests stop.
- rate_div  in  DIVW  clock cycles per cic_ce strobe; 0 and 1 both mean every cycle.
- clear_status  in  1  pulse; clears underflow and underflow_count.
- fifo_empty  in  1  FIFO empty flag.
- fifo_count  in  CW  FIFO fill level.
- fifo_i  in  IBITS  FIFO head I (show-ahead, valid while !fifo_empty).
- fifo_q  in  IBITS  FIFO head Q.
- fifo_rd  out  1  pop strobe, one cycle per sample.
- cic_ce  out  1  CIC clock_en strobe.
- cic_req  in  1  CIC request for next input sample.
- x_real  out  IBITS  held I to CIC.
- x_imag  out  IBITS  held Q to CIC.
- active  out  1  high in PRIME, RUN and FLUSH.
- underflow  out  1  sticky underflow flag.
- underflow_count  out  16  saturating count of zero-stuffed requests.

Behaviour:

Reset:
- Forces IDLE.
- fifo_rd=0, cic_ce=0, x_real=x_imag=0, active=0, underflow=0, underflow_count=0.
- Divider and flush counter are cleared.
- Reset asserted mid-RUN takes effect on the next edge; no pop is issued on that edge.

Divider:
- div_cnt counts 0..max(rate_div,1)-1 in PRIME, RUN and FLUSH; held at 0 in IDLE.
- cic_ce is registered and high for one cycle when div_cnt wraps, giving a strobe every max(rate_div,1) cycles.
- div_cnt compares against the live rate_div value, so a change takes effect by the next wrap; if div_cnt ≥ new value, it wraps next cycle.

State machine:
- IDLE: cic_ce low. If run=1, go to PRIME.
- PRIME: cic_ce runs, but every cic_req is answered with zero. If run=0, go to FLUSH. If fifo_count ≥ PRIME_DEPTH, go to RUN.
- RUN: on cic_req with !fifo_empty, drive fifo_rd=1 that same cycle and register x_real/x_imag ← fifo_i/fifo_q at that edge. On cic_req with fifo_empty, register zeros, keep fifo_rd=0, set underflow=1, and increment underflow_count (saturating at 16'hFFFF). If run=0, go to FLUSH; a cic_req in that same cycle is still serviced as RUN.
- FLUSH: each cic_req loads zeros and increments flush_cnt; no pops and no underflow counting. When flush_cnt reaches FLUSH_REQS, go to IDLE with x_real/x_imag=0. If run returns high in FLUSH, the flush completes first and then goes IDLE→PRIME.

Rules:
- fifo_rd is combinational from (state==RUN & cic_req & !fifo_empty) and is never high in any other state.
- Held sample registers change only on cic_req (or reset), so the value is stable for the CIC's next capture.
- clear_status takes priority over a same-cycle increment: result is count=0, flag=0.
- cic_req arriving when cic_ce is low is serviced identically; it is never ignored.
- active = (state != IDLE).

Test Plan:
1. rate_div=4, FIFO preloaded with 100 samples, run=1: PRIME exits on the first cycle count ≥64. cic_ce pulses every 4 cycles. Each cic_req pops exactly one sample and x_real equals the FIFO sequence in order.
2. rate_div=1: cic_ce is high every cycle. rate_div changed 1→3 mid-RUN: strobe spacing becomes 3 within one wrap with no missing pop.
3. FIFO drains to empty in RUN with 5 further cic_req: x_real=x_imag=0, fifo_rd never high, underflow=1, underflow_count=5. Then clear_status coincident with a 6th underflow req: count=0, flag=0.
4. run dropped in RUN: exactly 8 zero samples are loaded on 8 cic_req, then IDLE, cic_ce stops and active=0. run re-raised during FLUSH: 8 flush reqs complete, then PRIME.
5. reset pulsed while cic_req=1 and FIFO non-empty in RUN: no fifo_rd on that edge and all outputs return to reset values. underflow_count forced to 16'hFFFE then 3 underflows: count holds at 16'hFFFF.
